video_timing_gen: RTL and testbench

- Parametrised, runtime-reprogrammable raster timing generator; successor to the fixed 256x256 sync generator that drives the simulated CRT.
- Produces the following, all cycle-aligned to the same beam position:
  - h/v position counters
  - sync pulses with selectable polarity
  - blanking and display_on
  - line/frame strobes
  - a pixel clock-enable
- A new timing mode is accepted over a valid/ready handshake and takes effect only at a frame boundary, so no torn frames are ever produced.

---
 rtl/video_timing_gen_pkg.sv | 69 ++++++
 rtl/video_timing_gen_if.sv | 31 +++
 rtl/video_timing_gen_timing_axis.sv | 55 +++++
 rtl/video_timing_gen.sv | 134 +++++++++++++
 tb/tb_video_timing_gen.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_gen_pkg.sv
// rtl/video_timing_gen_pkg.sv - timing record type, reset-time mode constants and limit helpers
//   exports: tval_t/tsum_t, axis_t, mode_t, limits_t, make_axis, axis_total, axis_limits, axis_legal
package video_timing_gen_pkg;

  // Record fields are wider than any supported axis.
  // The sums below keep two extra bits, so adding four full-width fields cannot wrap.
  localparam int TW = 16;

  typedef logic [TW-1:0] tval_t;
  typedef logic [TW+1:0] tsum_t;

  // pre_sync is front (h) / bottom (v); post_sync is back (h) / top (v)
  typedef struct packed {
    tval_t display;
    tval_t pre_sync;
    tval_t sync;
    tval_t post_sync;
  } axis_t;

  typedef struct packed {
    axis_t h;
    axis_t v;
  } mode_t;

  typedef struct packed {
    tval_t max;
    tval_t sync_start;
    tval_t sync_end;
  } limits_t;

  localparam int DEF_H_DISPLAY = 256;
  localparam int DEF_H_FRONT   = 7;
  localparam int DEF_H_SYNC    = 23;
  localparam int DEF_H_BACK    = 23;
  localparam int DEF_V_DISPLAY = 256;
  localparam int DEF_V_BOTTOM  = 14;
  localparam int DEF_V_SYNC    = 3;
  localparam int DEF_V_TOP     = 5;

  function automatic axis_t make_axis(input int display, input int pre_sync,
                                      input int sync, input int post_sync);
    axis_t a;
    a.display   = tval_t'(display);
    a.pre_sync  = tval_t'(pre_sync);
    a.sync      = tval_t'(sync);
    a.post_sync = tval_t'(post_sync);
    return a;
  endfunction

  function automatic tsum_t axis_total(input axis_t a);
    return tsum_t'(a.display) + tsum_t'(a.pre_sync) + tsum_t'(a.sync) + tsum_t'(a.post_sync);
  endfunction

  function automatic limits_t axis_limits(input axis_t a);
    limits_t l;
    tsum_t   start_w;
    start_w      = tsum_t'(a.display) + tsum_t'(a.pre_sync);
    l.max        = tval_t'(axis_total(a) - tsum_t'(1));
    l.sync_start = tval_t'(start_w);
    l.sync_end   = tval_t'(start_w + tsum_t'(a.sync) - tsum_t'(1));
    return l;
  endfunction

  // A total of exactly 2^bits is legal: the counter's max is then all ones.
  function automatic logic axis_legal(input axis_t a, input int bits);
    return (a.display != '0) && (a.sync != '0) && (axis_total(a) <= (tsum_t'(1) << bits));
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - timing-mode offer channel
//   master: drives cfg_valid and the eight cfg_* fields; sees cfg_ready and cfg_err
//   slave : the generator side of the same signals
interface video_timing_gen_if #(
  parameter int H_BITS = 9,
  parameter int V_BITS = 9
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic              cfg_err;
  logic [H_BITS-1:0] cfg_h_display;
  logic [H_BITS-1:0] cfg_h_front;
  logic [H_BITS-1:0] cfg_h_sync;
  logic [H_BITS-1:0] cfg_h_back;
  logic [V_BITS-1:0] cfg_v_display;
  logic [V_BITS-1:0] cfg_v_bottom;
  logic [V_BITS-1:0] cfg_v_sync;
  logic [V_BITS-1:0] cfg_v_top;

  modport master (
    output cfg_valid, cfg_h_display, cfg_h_front, cfg_h_sync, cfg_h_back,
           cfg_v_display, cfg_v_bottom, cfg_v_sync, cfg_v_top,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_h_display, cfg_h_front, cfg_h_sync, cfg_h_back,
           cfg_v_display, cfg_v_bottom, cfg_v_sync, cfg_v_top,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/video_timing_gen_timing_axis.sv
// rtl/video_timing_gen_timing_axis.sv - one raster axis: position counter plus sync/blank decode
//   in : clk, reset (async, active-low), step (advance one position), cfg (axis timing record)
//   out: pos, sync (registered, POL when active), blank, at_max
module video_timing_gen_timing_axis
  import video_timing_gen_pkg::*;
#(
  parameter int BITS = 9,
  parameter bit POL  = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            step,
  input  axis_t           cfg,
  output logic [BITS-1:0] pos,
  output logic            sync,
  output logic            blank,
  output logic            at_max
);

  logic [BITS-1:0] pos_q, pos_d;
  logic            sync_q, sync_d;
  limits_t         lim;
  tval_t           pos_ext;
  tval_t           next_ext;

  always_comb begin
    lim      = axis_limits(cfg);
    pos_ext  = tval_t'(pos_q);
    at_max   = (pos_ext == lim.max);
    blank    = (pos_ext >= cfg.display);
    pos_d    = pos_q;
    sync_d   = sync_q;
    next_ext = '0;
    if (step) begin
      pos_d    = at_max ? '0 : pos_q + BITS'(1);
      next_ext = tval_t'(pos_d);
      // Decoding the next position lets sync line up with pos in the same cycle.
      sync_d   = ((next_ext >= lim.sync_start) && (next_ext <= lim.sync_end)) ? POL : ~POL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_q  <= '0;
      sync_q <= ~POL;
    end else begin
      pos_q  <= pos_d;
      sync_q <= sync_d;
    end
  end

  assign pos  = pos_q;
  assign sync = sync_q;

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - runtime-reprogrammable raster timing generator
//   in : clk, reset (async, active-low), cfg (slave side of the mode offer channel)
//   out: pix_ce, hpos, vpos, hsync, vsync, hblank, vblank, display_on, line_start, frame_start
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int H_BITS    = 9,
  parameter int V_BITS    = 9,
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_BOTTOM  = DEF_V_BOTTOM,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_TOP     = DEF_V_TOP,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int PIX_DIV   = 1
) (
  input  logic              clk,
  input  logic              reset,
  video_timing_gen_if.slave cfg,
  output logic              pix_ce,
  output logic [H_BITS-1:0] hpos,
  output logic [V_BITS-1:0] vpos,
  output logic              hsync,
  output logic              vsync,
  output logic              hblank,
  output logic              vblank,
  output logic              display_on,
  output logic              line_start,
  output logic              frame_start
);

  localparam int               DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam mode_t DEFAULT_MODE = '{
    h: make_axis(H_DISPLAY, H_FRONT, H_SYNC, H_BACK),
    v: make_axis(V_DISPLAY, V_BOTTOM, V_SYNC, V_TOP)
  };

  logic [DIV_W-1:0] div_q, div_d;
  logic             pending_q, pending_d;
  logic             err_q, err_d;
  mode_t            shadow_q, shadow_d;
  mode_t            active_q, active_d;
  mode_t            offered;
  logic             legal;
  logic             accept;
  logic             frame_wrap;
  logic             h_at_max, v_at_max;

  assign pix_ce = (div_q == DIV_LAST);

  always_comb begin
    div_d                = pix_ce ? '0 : div_q + DIV_W'(1);
    offered              = '0;
    offered.h.display    = tval_t'(cfg.cfg_h_display);
    offered.h.pre_sync   = tval_t'(cfg.cfg_h_front);
    offered.h.sync       = tval_t'(cfg.cfg_h_sync);
    offered.h.post_sync  = tval_t'(cfg.cfg_h_back);
    offered.v.display    = tval_t'(cfg.cfg_v_display);
    offered.v.pre_sync   = tval_t'(cfg.cfg_v_bottom);
    offered.v.sync       = tval_t'(cfg.cfg_v_sync);
    offered.v.post_sync  = tval_t'(cfg.cfg_v_top);
    legal      = axis_legal(offered.h, H_BITS) && axis_legal(offered.v, V_BITS);
    accept     = cfg.cfg_valid && !pending_q;
    frame_wrap = pix_ce && h_at_max && v_at_max;
    pending_d  = pending_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    err_d      = 1'b0;
    // A pending mode only swaps in as the beam returns to (0,0), so frames are never torn.
    // accept needs !pending_q, so it can never coincide with this swap.
    if (pending_q && frame_wrap) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      if (legal) begin
        pending_d = 1'b1;
        shadow_d  = offered;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      shadow_q  <= DEFAULT_MODE;
      active_q  <= DEFAULT_MODE;
    end else begin
      div_q     <= div_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
    end
  end

  video_timing_gen_timing_axis #(.BITS(H_BITS), .POL(HSYNC_POL)) u_h_axis (
    .clk    (clk),
    .reset  (reset),
    .step   (pix_ce),
    .cfg    (active_q.h),
    .pos    (hpos),
    .sync   (hsync),
    .blank  (hblank),
    .at_max (h_at_max)
  );

  video_timing_gen_timing_axis #(.BITS(V_BITS), .POL(VSYNC_POL)) u_v_axis (
    .clk    (clk),
    .reset  (reset),
    .step   (pix_ce && h_at_max),
    .cfg    (active_q.v),
    .pos    (vpos),
    .sync   (vsync),
    .blank  (vblank),
    .at_max (v_at_max)
  );

  assign cfg.cfg_ready = !pending_q;
  assign cfg.cfg_err   = err_q;
  assign display_on    = !hblank && !vblank;
  assign line_start    = pix_ce && (hpos == '0);
  assign frame_start   = line_start && (vpos == '0);

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for video_timing_gen over four parameter sets
module tb_video_timing_gen;

  typedef struct packed {
    logic       pix_ce;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic       hsync;
    logic       vsync;
    logic       hblank;
    logic       vblank;
    logic       display_on;
    logic       line_start;
    logic       frame_start;
    logic       cfg_ready;
    logic       cfg_err;
  } obs_t;

  typedef struct {
    int hd, hf, hs, hb, vd, vb, vs, vt;
  } mode_m;

  logic  clk = 1'b0;
  logic  reset = 1'b0;
  logic  off_valid [4];
  mode_m off_mode;
  obs_t  obs [4];

  int    checks = 0;
  int    errors = 0;
  obs_t  got;
  obs_t  exp_o;
  obs_t  exp_q [$];

  int    m_div [4];
  int    m_h [4];
  int    m_v [4];
  bit    m_pend [4];
  bit    m_err [4];
  mode_m m_act [4];
  mode_m m_sh [4];

  always #5 clk = ~clk;

  // 0: defaults, 1: PIX_DIV=3, 2: active-low syncs, 3: small reset-time mode
  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam bit SMALL = (g == 3);
    video_timing_gen_if #(.H_BITS(9), .V_BITS(9)) cif ();
    logic       pix_ce, hsync, vsync, hblank, vblank, display_on, line_start, frame_start;
    logic [8:0] hpos, vpos;

    assign cif.cfg_valid     = off_valid[g];
    assign cif.cfg_h_display = 9'(off_mode.hd);
    assign cif.cfg_h_front   = 9'(off_mode.hf);
    assign cif.cfg_h_sync    = 9'(off_mode.hs);
    assign cif.cfg_h_back    = 9'(off_mode.hb);
    assign cif.cfg_v_display = 9'(off_mode.vd);
    assign cif.cfg_v_bottom  = 9'(off_mode.vb);
    assign cif.cfg_v_sync    = 9'(off_mode.vs);
    assign cif.cfg_v_top     = 9'(off_mode.vt);

    video_timing_gen #(
      .H_BITS(9), .V_BITS(9),
      .H_DISPLAY(SMALL ? 16 : 256), .H_FRONT(SMALL ? 2 : 7),
      .H_SYNC(SMALL ? 3 : 23), .H_BACK(SMALL ? 3 : 23),
      .V_DISPLAY(SMALL ? 8 : 256), .V_BOTTOM(SMALL ? 1 : 14),
      .V_SYNC(SMALL ? 1 : 3), .V_TOP(SMALL ? 2 : 5),
      .HSYNC_POL(g != 2), .VSYNC_POL(g != 2), .PIX_DIV((g == 1) ? 3 : 1)
    ) dut (
      .clk(clk), .reset(reset), .cfg(cif.slave), .pix_ce(pix_ce),
      .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
      .hblank(hblank), .vblank(vblank), .display_on(display_on),
      .line_start(line_start), .frame_start(frame_start)
    );

    assign obs[g] = {pix_ce, hpos, vpos, hsync, vsync, hblank, vblank, display_on,
                     line_start, frame_start, cif.cfg_ready, cif.cfg_err};
  end

  function automatic mode_m def_mode(input int d);
    mode_m m;
    if (d == 3) m = '{16, 2, 3, 3, 8, 1, 1, 2};
    else        m = '{256, 7, 23, 23, 256, 14, 3, 5};
    return m;
  endfunction

  function automatic int pdiv(input int d);
    return (d == 1) ? 3 : 1;
  endfunction

  function automatic bit pol(input int d);
    return d != 2;
  endfunction

  function automatic bit legal_m(input mode_m m);
    return (m.hd != 0) && (m.hs != 0) && (m.vd != 0) && (m.vs != 0) &&
           (m.hd + m.hf + m.hs + m.hb <= 512) && (m.vd + m.vb + m.vs + m.vt <= 512);
  endfunction

  function automatic obs_t model_out(input int d);
    obs_t  o;
    mode_m a;
    int    h, v, hs0, vs0;
    bit    p;
    a   = m_act[d];
    h   = m_h[d];
    v   = m_v[d];
    p   = pol(d);
    hs0 = a.hd + a.hf;
    vs0 = a.vd + a.vb;
    o.pix_ce      = (m_div[d] == pdiv(d) - 1);
    o.hpos        = 9'(h);
    o.vpos        = 9'(v);
    o.hsync       = (h >= hs0 && h < hs0 + a.hs) ? p : !p;
    o.vsync       = (v >= vs0 && v < vs0 + a.vs) ? p : !p;
    o.hblank      = (h >= a.hd);
    o.vblank      = (v >= a.vd);
    o.display_on  = (h < a.hd) && (v < a.vd);
    o.line_start  = o.pix_ce && (h == 0);
    o.frame_start = o.pix_ce && (h == 0) && (v == 0);
    o.cfg_ready   = !m_pend[d];
    o.cfg_err     = m_err[d];
    return o;
  endfunction

  task automatic model_init();
    for (int d = 0; d < 4; d++) begin
      m_div[d]  = 0;
      m_h[d]    = 0;
      m_v[d]    = 0;
      m_pend[d] = 1'b0;
      m_err[d]  = 1'b0;
      m_act[d]  = def_mode(d);
      m_sh[d]   = def_mode(d);
    end
  endtask

  task automatic model_step(input int d);
    mode_m a;
    int    hmax, vmax;
    bit    ce, pend0;
    a     = m_act[d];
    hmax  = a.hd + a.hf + a.hs + a.hb - 1;
    vmax  = a.vd + a.vb + a.vs + a.vt - 1;
    ce    = (m_div[d] == pdiv(d) - 1);
    pend0 = m_pend[d];
    m_div[d] = ce ? 0 : m_div[d] + 1;
    if (ce) begin
      if (m_h[d] == hmax) begin
        m_h[d] = 0;
        if (m_v[d] == vmax) begin
          m_v[d] = 0;
          if (pend0) begin
            m_act[d]  = m_sh[d];
            m_pend[d] = 1'b0;
          end
        end else begin
          m_v[d] = m_v[d] + 1;
        end
      end else begin
        m_h[d] = m_h[d] + 1;
      end
    end
    m_err[d] = 1'b0;
    if (off_valid[d] && !pend0) begin
      if (legal_m(off_mode)) begin
        m_pend[d] = 1'b1;
        m_sh[d]   = off_mode;
      end else begin
        m_err[d] = 1'b1;
      end
    end
  endtask

  // One clock: model follows the edge, expectation is queued, DUT sampled on the falling edge.
  task automatic tick(input int d);
    @(posedge clk);
    model_step(d);
    exp_q.push_back(model_out(d));
    @(negedge clk);
    got = obs[d];
  endtask

  task automatic do_reset();
    for (int d = 0; d < 4; d++) off_valid[d] = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    model_init();
    exp_q.delete();
    reset = 1'b1;
  endtask

  task automatic offer(input int d, input mode_m m);
    off_mode     = m;
    off_valid[d] = 1'b1;
    tick(d);
    off_valid[d] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    model_init();
    for (int d = 0; d < 4; d++) exp_q.push_back(model_out(d));
    for (int d = 0; d < 4; d++) begin
      exp_o = exp_q.pop_front();
      checks++;
      if (obs[d] !== exp_o) begin
        errors++;
        $display("FAIL reset_state dut=%0d got=%h exp=%h", d, obs[d], exp_o);
      end
    end
  endtask

  task automatic test_defaults();
    int wraps = 0, hs_cnt = 0, first_hs = -1, prev_h = 0;
    do_reset();
    for (int i = 0; i < 3 * 309 + 10; i++) begin
      tick(0);
      exp_o = exp_q.pop_front();
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL defaults_cycle i=%0d got=%h exp=%h", i, got, exp_o);
      end
      if (prev_h == 308 && got.hpos == 0) wraps++;
      if (got.vpos == 1 && got.hsync) begin
        hs_cnt++;
        if (first_hs < 0) first_hs = int'(got.hpos);
      end
      prev_h = int'(got.hpos);
    end
    checks++;
    if (wraps != 3) begin errors++; $display("FAIL defaults_hwraps got=%0d exp=3", wraps); end
    checks++;
    if (hs_cnt != 23) begin errors++; $display("FAIL defaults_hsync_width got=%0d exp=23", hs_cnt); end
    checks++;
    if (first_hs != 263) begin errors++; $display("FAIL defaults_hsync_start got=%0d exp=263", first_hs); end
  endtask

  task automatic test_frame();
    int fs = 0, vs_cnt = 0;
    do_reset();
    for (int i = 0; i < 2 * 288; i++) begin
      tick(3);
      exp_o = exp_q.pop_front();
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL frame_cycle i=%0d got=%h exp=%h", i, got, exp_o);
      end
      if (got.frame_start) fs++;
      if (got.vsync) vs_cnt++;
    end
    checks++;
    if (fs != 2) begin errors++; $display("FAIL frame_start_count got=%0d exp=2", fs); end
    checks++;
    if (vs_cnt != 48) begin errors++; $display("FAIL frame_vsync_samples got=%0d exp=48", vs_cnt); end
  endtask

  task automatic test_pix_div();
    int first_move = -1, last_ls = -1, bad_period = 0, periods = 0;
    do_reset();
    for (int i = 1; i <= 3 * 927 + 5; i++) begin
      tick(1);
      exp_o = exp_q.pop_front();
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL pixdiv_cycle i=%0d got=%h exp=%h", i, got, exp_o);
      end
      if (first_move < 0 && got.hpos != 0) first_move = i;
      if (got.line_start) begin
        if (last_ls >= 0) begin
          periods++;
          if (i - last_ls != 927) bad_period++;
        end
        last_ls = i;
      end
    end
    checks++;
    if (first_move != 3) begin errors++; $display("FAIL pixdiv_first_step got=%0d exp=3", first_move); end
    checks++;
    if (periods != 3 || bad_period != 0) begin
      errors++;
      $display("FAIL pixdiv_line_period periods=%0d bad=%0d exp periods=3 bad=0", periods, bad_period);
    end
  endtask

  task automatic test_mode_switch();
    int switched = 0, hmax_seen = 0, vmax_seen = 0, early = 0;
    do_reset();
    for (int i = 0; i < 50; i++) begin
      tick(3);
      exp_o = exp_q.pop_front();
      checks++;
      if (got !== exp_o) begin errors++; $display("FAIL switch_pre i=%0d got=%h exp=%h", i, got, exp_o); end
    end
    offer(3, '{8, 2, 3, 1, 4, 1, 1, 1});
    exp_o = exp_q.pop_front();
    checks++;
    if (got !== exp_o || got.cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL switch_accept got=%h exp=%h", got, exp_o);
    end
    for (int i = 0; i < 450; i++) begin
      tick(3);
      exp_o = exp_q.pop_front();
      checks++;
      if (got !== exp_o) begin errors++; $display("FAIL switch_cycle i=%0d got=%h exp=%h", i, got, exp_o); end
      if (switched == 0 && got.cfg_ready) begin
        switched = 1;
        if (got.hpos != 0 || got.vpos != 0) early = 1;
      end else if (switched != 0) begin
        if (int'(got.hpos) > hmax_seen) hmax_seen = int'(got.hpos);
        if (int'(got.vpos) > vmax_seen) vmax_seen = int'(got.vpos);
      end
    end
    checks++;
    if (switched == 0 || early != 0) begin
      errors++;
      $display("FAIL switch_boundary switched=%0d off_origin=%0d exp 1/0", switched, early);
    end
    checks++;
    if (hmax_seen != 13 || vmax_seen != 6) begin
      errors++;
      $display("FAIL switch_new_max got=%0d/%0d exp=13/6", hmax_seen, vmax_seen);
    end
  endtask

  task automatic test_illegal();
    int err_cnt = 0, not_ready = 0;
    mode_m bad [3];
    bad[0] = '{256, 7, 0, 23, 256, 14, 3, 5};
    bad[1] = '{500, 5, 5, 5, 256, 14, 3, 5};
    bad[2] = '{256, 7, 23, 23, 500, 5, 5, 5};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 7; i++) begin
        if (i == 2) offer(0, bad[k]);
        else tick(0);
        exp_o = exp_q.pop_front();
        checks++;
        if (got !== exp_o) begin errors++; $display("FAIL illegal_cycle k=%0d i=%0d got=%h exp=%h", k, i, got, exp_o); end
        if (got.cfg_err) err_cnt++;
        if (!got.cfg_ready) not_ready++;
      end
    end
    checks++;
    if (err_cnt != 3) begin errors++; $display("FAIL illegal_err_pulses got=%0d exp=3", err_cnt); end
    checks++;
    if (not_ready != 0) begin errors++; $display("FAIL illegal_ready_drop got=%0d exp=0", not_ready); end
  endtask

  task automatic test_polarity();
    int low_cnt = 0, first_low = -1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs[2].hsync !== 1'b1 || obs[2].vsync !== 1'b1) begin
      errors++;
      $display("FAIL polarity_reset_idle got=%b%b exp=11", obs[2].hsync, obs[2].vsync);
    end
    do_reset();
    for (int i = 0; i < 2 * 309; i++) begin
      tick(2);
      exp_o = exp_q.pop_front();
      checks++;
      if (got !== exp_o) begin errors++; $display("FAIL polarity_cycle i=%0d got=%h exp=%h", i, got, exp_o); end
      if (!got.hsync) begin
        low_cnt++;
        if (first_low < 0) first_low = int'(got.hpos);
      end
    end
    checks++;
    if (low_cnt != 46 || first_low != 263) begin
      errors++;
      $display("FAIL polarity_window low=%0d start=%0d exp=46/263", low_cnt, first_low);
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    do_reset();
    offer(0, '{256, 100, 100, 56, 8, 1, 1, 1});
    exp_o = exp_q.pop_front();
    checks++;
    if (got !== exp_o || got.cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_boundary_accept got=%h exp=%h", got, exp_o);
    end
    while (!(got.vpos == 1 && got.hpos == 100) && guard < 700) begin
      tick(0);
      exp_o = exp_q.pop_front();
      checks++;
      if (got !== exp_o) begin errors++; $display("FAIL async_pre got=%h exp=%h", got, exp_o); end
      guard++;
    end
    checks++;
    if (guard >= 700) begin errors++; $display("FAIL async_reach_pos timeout at h=%0d v=%0d", got.hpos, got.vpos); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs[0].hpos !== 9'd0 || obs[0].vpos !== 9'd0 || obs[0].cfg_ready !== 1'b1 || obs[0].hsync !== 1'b0) begin
      errors++;
      $display("FAIL async_immediate h=%0d v=%0d rdy=%b hs=%b exp 0/0/1/0",
               obs[0].hpos, obs[0].vpos, obs[0].cfg_ready, obs[0].hsync);
    end
    model_init();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 320; i++) begin
      tick(0);
      exp_o = exp_q.pop_front();
      checks++;
      if (got !== exp_o) begin errors++; $display("FAIL async_post i=%0d got=%h exp=%h", i, got, exp_o); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 4; d++) off_valid[d] = 1'b0;
    off_mode = def_mode(0);
    test_reset();
    test_defaults();
    test_frame();
    test_pix_div();
    test_mode_switch();
    test_illegal();
    test_polarity();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
